// File: rtl/counter_ext_pkg.sv
// rtl/counter_ext_pkg.sv - shared types for the extended counter
// Boundary behaviour is selected once at elaboration from the SATURATE parameter.
package counter_ext_pkg;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

  function automatic mode_e mode_of(input int unsigned saturate);
    return (saturate != 0) ? MODE_SAT : MODE_WRAP;
  endfunction

endpackage

// File: rtl/counter_ext_tick_divider.sv
// rtl/counter_ext_tick_divider.sv - prescaler producing the counter step strobe
// The >= compare lets a psc decrease below the running count fire on the next en cycle.
module counter_ext_tick_divider #(
  parameter int unsigned PSC_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             restart_i,
  input  logic [PSC_W-1:0] psc_i,
  output logic             tick_o
);

  logic [PSC_W-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && !reset && (cnt_q >= psc_i);

  always_comb begin
    cnt_d = cnt_q;
    if (restart_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + PSC_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/counter_ext.sv
// rtl/counter_ext.sv - prescaled up/down counter with limit, wrap/saturate and flags
// Priority per edge: clr > load > step > hold; clr/load also restart the prescaler.
module counter_ext
  import counter_ext_pkg::*;
#(
  parameter int unsigned       WIDTH    = 32,
  parameter logic [WIDTH-1:0]  PRESET   = '0,
  parameter int unsigned       PSC_W    = 8,
  parameter int unsigned       SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [PSC_W-1:0] psc,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] q,
  output logic             tick,
  output logic             wrap,
  output logic             ovf_sticky,
  input  logic             ovf_clr
);

  localparam mode_e MODE = mode_of(SATURATE);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic             step;
  logic             at_bound;

  counter_ext_tick_divider #(
    .PSC_W (PSC_W)
  ) u_div (
    .clk       (clk),
    .reset     (reset),
    .en_i      (en),
    .restart_i (clr || load),
    .psc_i     (psc),
    .tick_o    (tick)
  );

  // Up-count boundary uses >= so a loaded value above limit folds back on the next step.
  always_comb begin
    step     = tick && !clr && !load;
    at_bound = up ? (q_q >= limit) : (q_q == '0);
    q_d      = q_q;
    wrap_d   = 1'b0;
    if (clr) begin
      q_d = PRESET;
    end else if (load) begin
      q_d = load_val;
    end else if (step) begin
      if (at_bound) begin
        wrap_d = 1'b1;
        if (up) begin
          q_d = (MODE == MODE_SAT) ? limit : '0;
        end else begin
          q_d = (MODE == MODE_SAT) ? '0 : limit;
        end
      end else begin
        q_d = up ? q_q + WIDTH'(1) : q_q - WIDTH'(1);
      end
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (step && at_bound) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q    <= PRESET;
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
      ovf_q  <= ovf_d;
    end
  end

  assign q          = q_q;
  assign wrap       = wrap_q;
  assign ovf_sticky = ovf_q;

endmodule

// File: tb/tb_counter_ext.sv
// tb/tb_counter_ext.sv - directed bench for counter_ext in wrap and saturate builds
module tb_counter_ext;

  logic       clk;
  logic       reset;
  logic       en, up, clr, load, ovf_clr;
  logic [7:0] load_val, limit;
  logic [3:0] psc;
  logic [7:0] qa, qb;
  logic       ticka, tickb, wrapa, wrapb, ovfa, ovfb;

  int errors = 0;
  int checks = 0;

  counter_ext #(.WIDTH(8), .PRESET(8'd0), .PSC_W(4), .SATURATE(0)) dut_a (
    .clk(clk), .reset(reset), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .psc(psc), .limit(limit), .q(qa), .tick(ticka),
    .wrap(wrapa), .ovf_sticky(ovfa), .ovf_clr(ovf_clr)
  );

  counter_ext #(.WIDTH(8), .PRESET(8'd5), .PSC_W(4), .SATURATE(1)) dut_b (
    .clk(clk), .reset(reset), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .psc(psc), .limit(limit), .q(qb), .tick(tickb),
    .wrap(wrapb), .ovf_sticky(ovfb), .ovf_clr(ovf_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic       e, u, c, l, oc;
    logic [7:0] lv;
    logic [3:0] p;
    logic [7:0] lim;
    logic       tk;
    logic [7:0] q;
    logic       w, o;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic e, input logic u, input logic c, input logic l,
                       input logic oc, input logic [7:0] lv, input logic [3:0] p,
                       input logic [7:0] lim);
    @(negedge clk);
    en = e; up = u; clr = c; load = l; ovf_clr = oc;
    load_val = lv; psc = p; limit = lim;
    #1;
  endtask

  task automatic clk_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    en = 0; up = 0; clr = 0; load = 0; ovf_clr = 0;
    load_val = 0; psc = 0; limit = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  logic [7:0] mq;
  logic       mt, mw;

  initial begin
    //                 e  u  c  l  oc lv     p     lim    tk q      w  o
    tbl[0]  = '{1, 1, 0, 1, 0, 8'd9, 4'd0, 8'd4, 1, 8'd9, 0, 0};
    tbl[1]  = '{1, 1, 0, 0, 0, 8'd0, 4'd0, 8'd4, 1, 8'd0, 1, 1};
    tbl[2]  = '{1, 1, 0, 0, 0, 8'd0, 4'd0, 8'd4, 1, 8'd1, 0, 1};
    tbl[3]  = '{0, 1, 0, 0, 1, 8'd0, 4'd0, 8'd4, 0, 8'd1, 0, 0};
    tbl[4]  = '{1, 0, 0, 0, 0, 8'd0, 4'd0, 8'd4, 1, 8'd0, 0, 0};
    tbl[5]  = '{1, 0, 0, 0, 0, 8'd0, 4'd0, 8'd4, 1, 8'd4, 1, 1};
    tbl[6]  = '{1, 1, 0, 0, 1, 8'd0, 4'd0, 8'd4, 1, 8'd0, 1, 1};
    tbl[7]  = '{0, 1, 0, 0, 1, 8'd0, 4'd0, 8'd4, 0, 8'd0, 0, 0};
    tbl[8]  = '{1, 1, 1, 1, 0, 8'd7, 4'd0, 8'd4, 1, 8'd0, 0, 0};
    tbl[9]  = '{1, 1, 0, 1, 0, 8'd3, 4'd0, 8'd4, 1, 8'd3, 0, 0};
    tbl[10] = '{1, 1, 1, 0, 0, 8'd0, 4'd0, 8'd4, 1, 8'd0, 0, 0};
    tbl[11] = '{1, 1, 0, 0, 0, 8'd0, 4'd0, 8'd0, 1, 8'd0, 1, 1};
    tbl[12] = '{1, 1, 0, 0, 0, 8'd0, 4'd0, 8'd0, 1, 8'd0, 1, 1};
    tbl[13] = '{0, 1, 0, 0, 0, 8'd0, 4'd0, 8'd0, 0, 8'd0, 0, 1};
    tbl[14] = '{1, 1, 0, 1, 0, 8'd2, 4'd0, 8'd4, 1, 8'd2, 0, 1};
    tbl[15] = '{1, 1, 0, 1, 0, 8'd4, 4'd0, 8'd4, 1, 8'd4, 0, 1};
    tbl[16] = '{1, 1, 0, 1, 0, 8'd1, 4'd0, 8'd4, 1, 8'd1, 0, 1};

    reset = 1'b1;
    en = 0; up = 0; clr = 0; load = 0; ovf_clr = 0;
    load_val = 0; psc = 0; limit = 0;
    #12;
    chk("rst_qa", qa, 0);
    chk("rst_qb_preset", qb, 5);
    chk("rst_wrap", wrapa, 0);
    chk("rst_ovf", ovfa, 0);
    @(negedge clk);
    reset = 1'b0;

    // Prescaled up count in wrap mode: step every 4th en cycle, 0..5 then 0.
    mq = 0;
    for (int k = 0; k < 26; k++) begin
      drive(1, 1, 0, 0, 0, 8'd0, 4'd3, 8'd5);
      mt = ((k % 4) == 3);
      mw = 1'b0;
      chk($sformatf("psc_tick[%0d]", k), ticka, mt);
      if (mt) begin
        mw = (mq == 5);
        mq = (mq == 5) ? 8'd0 : mq + 8'd1;
      end
      clk_edge();
      chk($sformatf("psc_q[%0d]", k), qa, mq);
      chk($sformatf("psc_wrap[%0d]", k), wrapa, mw);
      if (k == 3) chk("psc_ovf_before", ovfa, 0);
    end
    chk("psc_ovf_after", ovfa, 1);

    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].e, tbl[i].u, tbl[i].c, tbl[i].l, tbl[i].oc, tbl[i].lv, tbl[i].p, tbl[i].lim);
      chk($sformatf("tbl_tick[%0d]", i), ticka, tbl[i].tk);
      clk_edge();
      chk($sformatf("tbl_q[%0d]", i), qa, tbl[i].q);
      chk($sformatf("tbl_wrap[%0d]", i), wrapa, tbl[i].w);
      chk($sformatf("tbl_ovf[%0d]", i), ovfa, tbl[i].o);
    end

    // psc lowered below the running prescale count: tick next cycle, then every 3.
    drive(1, 1, 1, 0, 0, 8'd0, 4'd7, 8'd200);
    clk_edge();
    for (int k = 0; k < 6; k++) begin
      drive(1, 1, 0, 0, 0, 8'd0, 4'd7, 8'd200);
      chk($sformatf("psc7_tick[%0d]", k), ticka, 0);
      clk_edge();
    end
    for (int k = 0; k < 7; k++) begin
      drive(1, 1, 0, 0, 0, 8'd0, 4'd2, 8'd200);
      chk($sformatf("psc2_tick[%0d]", k), ticka, (k % 3) == 0);
      clk_edge();
    end
    chk("psc2_q", qa, 3);

    // Saturate build counting down from 2 holds at 0 and pulses wrap each held step.
    do_reset();
    drive(1, 0, 0, 1, 0, 8'd2, 4'd0, 8'd9);
    clk_edge();
    chk("sat_load", qb, 2);
    for (int k = 0; k < 4; k++) begin
      drive(1, 0, 0, 0, 0, 8'd0, 4'd0, 8'd9);
      clk_edge();
      chk($sformatf("sat_q[%0d]", k), qb, (k == 0) ? 1 : 0);
      chk($sformatf("sat_wrap[%0d]", k), wrapb, k >= 2);
      chk($sformatf("sat_ovf[%0d]", k), ovfb, k >= 2);
    end

    // Asynchronous reset mid-count takes effect before the next clock edge.
    drive(1, 1, 0, 1, 0, 8'd7, 4'd0, 8'd9);
    clk_edge();
    chk("pre_rst_q", qa, 7);
    chk("pre_rst_ovf", ovfa, 1);
    drive(1, 1, 0, 0, 0, 8'd0, 4'd0, 8'd9);
    reset = 1'b1;
    #1;
    chk("async_q", qa, 0);
    chk("async_qb", qb, 5);
    chk("async_wrap", wrapa, 0);
    chk("async_ovf", ovfa, 0);
    chk("async_tick", ticka, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_tick", ticka, 1);
    clk_edge();
    chk("post_rst_q", qa, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
